// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-cycle controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
    } lcd_state_e;

    // Bit positions inside the LSU io_lcd word
    localparam int unsigned LCD_ON_BIT  = 31;
    localparam int unsigned LCD_TOG_BIT = 10;
    localparam int unsigned LCD_RS_BIT  = 9;
    localparam int unsigned LCD_RW_BIT  = 8;

    // Commands that need the long clear/home execution wait
    localparam logic [7:0] LCD_CLR_OP      = 8'h01;
    localparam logic [7:0] LCD_HOME_OP     = 8'h02;
    localparam logic [7:0] LCD_HOME_ALT_OP = 8'h03;

    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CLR_OP || data == LCD_HOME_OP || data == LCD_HOME_ALT_OP);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter that saturates at zero; zero_o flags expiry.
module lcd_delay_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Turns toggle-strobed io_lcd words into timed HD44780 write cycles,
// with a one-deep pending slot and sticky error flags.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 4,
    parameter int unsigned T_EXEC_CYC  = 2500,
    parameter int unsigned T_CLR_CYC   = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_lcd_i,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o,
    output logic        busy_o,
    output logic        err_rw_o,
    output logic        err_ovf_o
);

    localparam int unsigned MAX_A = (T_SETUP_CYC > T_EN_CYC) ? T_SETUP_CYC : T_EN_CYC;
    localparam int unsigned MAX_B = (T_HOLD_CYC > T_EXEC_CYC) ? T_HOLD_CYC : T_EXEC_CYC;
    localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_T = (MAX_C > T_CLR_CYC) ? MAX_C : T_CLR_CYC;
    localparam int unsigned CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_CYC - 1);

    lcd_state_e       state_q;
    logic             tog_q;
    logic             pend_valid_q;
    logic             pend_rs_q;
    logic [7:0]       pend_data_q;
    logic             req, req_ok, req_rw, wait_done;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             unused_io;

    assign unused_io = ^{io_lcd_i[30:11]};

    assign req       = (io_lcd_i[LCD_TOG_BIT] != tog_q);
    assign req_ok    = req && !io_lcd_i[LCD_RW_BIT];
    assign req_rw    = req && io_lcd_i[LCD_RW_BIT];
    assign wait_done = (state_q == WAIT) && cnt_zero;

    assign lcd_rw_o = 1'b0;
    assign busy_o   = (state_q != IDLE) || pend_valid_q;

    // Counter reload mirrors every state transition taken by the FSM below
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            IDLE:  if (req_ok)   begin cnt_load = 1'b1; cnt_val = LD_SETUP; end
            SETUP: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = LD_EN;    end
            PULSE: if (cnt_zero) begin cnt_load = 1'b1; cnt_val = LD_HOLD;  end
            HOLD:  if (cnt_zero) begin
                cnt_load = 1'b1;
                cnt_val  = is_slow_cmd(lcd_rs_o, lcd_data_o) ? LD_CLR : LD_EXEC;
            end
            WAIT:  if (cnt_zero && (pend_valid_q || req_ok)) begin
                cnt_load = 1'b1;
                cnt_val  = LD_SETUP;
            end
            default: ;
        endcase
    end

    lcd_delay_cnt #(.WIDTH(CNT_W)) u_delay (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Write-cycle FSM, toggle detector, pending slot and sticky flags
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            tog_q        <= io_lcd_i[LCD_TOG_BIT];
            pend_valid_q <= 1'b0;
            pend_rs_q    <= 1'b0;
            pend_data_q  <= '0;
            lcd_data_o   <= '0;
            lcd_rs_o     <= 1'b0;
            lcd_en_o     <= 1'b0;
            lcd_on_o     <= 1'b0;
            err_rw_o     <= 1'b0;
            err_ovf_o    <= 1'b0;
        end else begin
            tog_q    <= io_lcd_i[LCD_TOG_BIT];
            lcd_on_o <= io_lcd_i[LCD_ON_BIT];
            if (req_rw) err_rw_o <= 1'b1;

            unique case (state_q)
                IDLE: if (req_ok) begin
                    lcd_data_o <= io_lcd_i[7:0];
                    lcd_rs_o   <= io_lcd_i[LCD_RS_BIT];
                    state_q    <= SETUP;
                end
                SETUP: if (cnt_zero) begin
                    state_q  <= PULSE;
                    lcd_en_o <= 1'b1;
                end
                PULSE: if (cnt_zero) begin
                    state_q  <= HOLD;
                    lcd_en_o <= 1'b0;
                end
                HOLD: if (cnt_zero) state_q <= WAIT;
                WAIT: if (cnt_zero) begin
                    if (pend_valid_q) begin
                        lcd_data_o   <= pend_data_q;
                        lcd_rs_o     <= pend_rs_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= SETUP;
                    end else if (req_ok) begin
                        lcd_data_o <= io_lcd_i[7:0];
                        lcd_rs_o   <= io_lcd_i[LCD_RS_BIT];
                        state_q    <= SETUP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A request arriving while busy parks in the slot; at WAIT exit the
            // slot is drained first, so this later write refills it, and only a
            // request meeting an empty slot at WAIT exit bypasses it.
            if (req_ok && (state_q != IDLE) && !(wait_done && !pend_valid_q)) begin
                pend_valid_q <= 1'b1;
                pend_rs_q    <= io_lcd_i[LCD_RS_BIT];
                pend_data_q  <= io_lcd_i[7:0];
                if (pend_valid_q && !wait_done) err_ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] io_lcd_i;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o;
    logic        busy_o, err_rw_o, err_ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Observation results
    int         busy_n, en_n, pulses, en_first, last_pulse_first;
    logic [7:0] first_data, last_en_data;
    logic       first_rs, first_on, saw42;

    lcd_ctrl #(
        .T_SETUP_CYC (2),
        .T_EN_CYC    (3),
        .T_HOLD_CYC  (2),
        .T_EXEC_CYC  (5),
        .T_CLR_CYC   (10)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .io_lcd_i   (io_lcd_i),
        .lcd_data_o (lcd_data_o),
        .lcd_rs_o   (lcd_rs_o),
        .lcd_rw_o   (lcd_rw_o),
        .lcd_en_o   (lcd_en_o),
        .lcd_on_o   (lcd_on_o),
        .busy_o     (busy_o),
        .err_rw_o   (err_rw_o),
        .err_ovf_o  (err_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample at negedges after an accept; optional mid-stream drives after sampling
    task automatic observe(input int max_cyc,
                           input int inj1_c, input logic [31:0] inj1_v,
                           input int inj2_c, input logic [31:0] inj2_v);
        logic en_prev;
        busy_n = 0; en_n = 0; pulses = 0; en_first = 0; last_pulse_first = 0;
        first_data = '0; first_rs = 1'b0; first_on = 1'b0; last_en_data = '0;
        saw42 = 1'b0; en_prev = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                first_data = lcd_data_o;
                first_rs   = lcd_rs_o;
                first_on   = lcd_on_o;
            end
            if (lcd_data_o == 8'h42) saw42 = 1'b1;
            if (lcd_en_o) begin
                en_n++;
                last_en_data = lcd_data_o;
                if (!en_prev) begin
                    pulses++;
                    last_pulse_first = c;
                    if (en_first == 0) en_first = c;
                end
            end
            en_prev = lcd_en_o;
            if (c == inj1_c) io_lcd_i = inj1_v;
            if (c == inj2_c) io_lcd_i = inj2_v;
            if (!busy_o) break;
            busy_n++;
        end
    endtask

    task automatic do_reset(input logic [31:0] io_v);
        @(negedge clk_i);
        rst_ni   = 1'b0;
        io_lcd_i = io_v;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        int bad;
        rst_ni   = 1'b0;
        io_lcd_i = 32'h0;

        // 1: reset with toggle bit high, no spurious transaction
        do_reset(32'h0000_0400);
        @(negedge clk_i);
        check("rst_data", {24'h0, lcd_data_o}, 32'h0);
        check("rst_flags", {25'h0, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, err_rw_o, err_ovf_o, busy_o}, 32'h0);
        bad = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (busy_o || lcd_en_o) bad++;
        end
        check("rst_no_txn", bad, 0);

        // 2: data write RS=1, DATA=0x41
        do_reset(32'h0);
        @(negedge clk_i);
        io_lcd_i = 32'h8000_0641;
        observe(40, 0, 0, 0, 0);
        check("t2_data", {24'h0, first_data}, 32'h41);
        check("t2_rs", first_rs, 1);
        check("t2_on", first_on, 1);
        check("t2_rw", lcd_rw_o, 0);
        check("t2_en_first", en_first, 3);
        check("t2_en_len", en_n, 3);
        check("t2_busy_len", busy_n, 12);

        // 3: clear command uses long wait
        io_lcd_i = 32'h8000_0001;
        observe(40, 0, 0, 0, 0);
        check("t3_data", {24'h0, first_data}, 32'h01);
        check("t3_rs", first_rs, 0);
        check("t3_pulses", pulses, 1);
        check("t3_en_len", en_n, 3);
        check("t3_busy_len", busy_n, 17);
        check("t3_ovf_clear", err_ovf_o, 0);

        // 4: two requests queued during a transaction, latest wins
        io_lcd_i = 32'h8000_0450;
        observe(60, 2, 32'h8000_0242, 4, 32'h8000_0643);
        check("t4_first", {24'h0, first_data}, 32'h50);
        check("t4_pulses", pulses, 2);
        check("t4_en_total", en_n, 6);
        check("t4_second_start", last_pulse_first, 15);
        check("t4_second_data", {24'h0, last_en_data}, 32'h43);
        check("t4_no_42", saw42, 0);
        check("t4_busy_len", busy_n, 24);
        check("t4_ovf", err_ovf_o, 1);
        check("t4_rw_clear", err_rw_o, 0);

        // 5: RW=1 request dropped, sticky err_rw
        do_reset(32'h0);
        @(negedge clk_i);
        check("t5_ovf_reset", err_ovf_o, 0);
        io_lcd_i = 32'h0000_0541;
        observe(20, 0, 0, 0, 0);
        check("t5_busy", busy_n, 0);
        check("t5_pulses", pulses, 0);
        repeat (5) @(negedge clk_i);
        check("t5_err_rw", err_rw_o, 1);
        check("t5_busy_idle", busy_o, 0);

        // 6: reset during PULSE aborts at that edge
        io_lcd_i = 32'h0000_0241;
        repeat (3) @(negedge clk_i);
        check("t6_en_pulse", lcd_en_o, 1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("t6_en_rst", lcd_en_o, 0);
        check("t6_busy_rst", busy_o, 0);
        check("t6_err_rw_rst", err_rw_o, 0);
        check("t6_data_rst", {24'h0, lcd_data_o}, 32'h0);
        rst_ni = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (busy_o || lcd_en_o) bad++;
        end
        check("t6_no_resume", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
